// File: rtl/phy_tx_stripe_ser.sv
// rtl/phy_tx_stripe_ser.sv - byte striper and N-lane parallel-to-serial transmitter
//
// Purpose:
//   Accepts bytes over a valid/ready handshake, stripes them round-robin into
//   one staging slot per lane, and on every frame boundary loads all lanes'
//   shift registers at once. Lanes with no staged byte send IDLE_SYM.
//
// Ports:
//   clk_8f       in   serial bit clock
//   reset_L      in   asynchronous active-low reset
//   data_in      in   input symbol (DATA_W bits)
//   valid_in     in   data_in valid
//   ready_out    out  a byte can be accepted this cycle
//   transfer     out  serial bit per lane (bit i = lane i)
//   lane_active  out  1 = lane is shifting real data, 0 = IDLE_SYM
//   frame_start  out  1-cycle pulse coincident with the first bit of a frame

module phy_tx_stripe_ser #(
  parameter int                N_LANES   = 2,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_SYM  = 8'hBC,
  parameter bit                MSB_FIRST = 1'b1
) (
  input  logic               clk_8f,
  input  logic               reset_L,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [N_LANES-1:0] transfer,
  output logic [N_LANES-1:0] lane_active,
  output logic               frame_start
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int PTR_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_LANES - 1);

  logic [CNT_W-1:0]   r_cnt;
  logic [PTR_W-1:0]   r_ptr;
  logic [N_LANES-1:0] r_full;
  logic [DATA_W-1:0]  r_slot  [N_LANES];
  logic [DATA_W-1:0]  r_shift [N_LANES];

  logic               w_load;
  logic               w_accept;
  logic [DATA_W-1:0]  w_shift_next [N_LANES];

  // The last bit cycle of a frame hands every slot to the shifters; refusing
  // input on that cycle means a slot is never written and consumed together.
  assign w_load    = (r_cnt == CNT_LAST);
  assign ready_out = ~r_full[r_ptr] && ~w_load;
  assign w_accept  = valid_in && ready_out;

  always_comb begin
    for (int i = 0; i < N_LANES; i++) begin
      if (w_load) begin
        w_shift_next[i] = r_full[i] ? r_slot[i] : IDLE_SYM;
      end else if (MSB_FIRST) begin
        w_shift_next[i] = {r_shift[i][DATA_W-2:0], 1'b0};
      end else begin
        w_shift_next[i] = {1'b0, r_shift[i][DATA_W-1:1]};
      end
    end
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_full      <= '0;
      transfer    <= '0;
      lane_active <= '0;
      frame_start <= 1'b0;
      for (int i = 0; i < N_LANES; i++) begin
        r_slot[i]  <= '0;
        r_shift[i] <= '0;
      end
    end else begin
      r_cnt       <= w_load ? '0 : r_cnt + 1'b1;
      frame_start <= w_load;

      // transfer mirrors the output end of the updated shifter so the first
      // bit of a freshly loaded symbol is on the line right after the load.
      for (int i = 0; i < N_LANES; i++) begin
        r_shift[i]  <= w_shift_next[i];
        transfer[i] <= MSB_FIRST ? w_shift_next[i][DATA_W-1] : w_shift_next[i][0];
      end

      if (w_load) begin
        lane_active <= r_full;
        r_full      <= '0;
        r_ptr       <= '0;
      end else if (w_accept) begin
        r_slot[r_ptr] <= data_in;
        r_full[r_ptr] <= 1'b1;
        r_ptr         <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phy_tx_stripe_ser.sv
// tb/tb_phy_tx_stripe_ser.sv - directed vector bench for phy_tx_stripe_ser

module tb_phy_tx_stripe_ser;

  logic       clk;
  logic       reset_L;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic [1:0] transfer;
  logic [1:0] lane_active;
  logic       frame_start;

  int n_vec;
  int n_fail;

  phy_tx_stripe_ser #(
    .N_LANES  (2),
    .DATA_W   (8),
    .IDLE_SYM (8'hBC),
    .MSB_FIRST(1'b1)
  ) dut (
    .clk_8f     (clk),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .transfer   (transfer),
    .lane_active(lane_active),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         nb;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [1:0] ea;
  } vec_t;

  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered on the first-bit sample of a frame; runs exactly one frame,
  // driving up to two bytes at the start and capturing both lanes' symbols.
  task automatic run_frame(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                           input string tag, output logic [7:0] c0, output logic [7:0] c1,
                           output logic [1:0] act, output logic fs);
    fs  = frame_start;
    act = lane_active;
    for (int j = 0; j < 8; j++) begin
      c0[7-j] = transfer[0];
      c1[7-j] = transfer[1];
      if (j < nb) begin
        data_in  = (j == 0) ? b0 : b1;
        valid_in = 1'b1;
        check({tag, "_ready"}, ready_out, 1'b1);
      end else begin
        valid_in = 1'b0;
      end
      step();
    end
    valid_in = 1'b0;
  endtask

  task automatic idle_frame_check(input string tag, input logic [7:0] e0,
                                  input logic [7:0] e1, input logic [1:0] ea);
    logic [7:0] c0, c1;
    logic [1:0] a;
    logic       fs;
    run_frame(0, 8'h00, 8'h00, tag, c0, c1, a, fs);
    check({tag, "_fs"}, fs, 1'b1);
    check({tag, "_lane0"}, c0, e0);
    check({tag, "_lane1"}, c1, e1);
    check({tag, "_active"}, a, ea);
  endtask

  initial begin
    logic [7:0] c0, c1;
    logic [1:0] a;
    logic       fs;
    logic [7:0] pe0, pe1;
    logic [1:0] pea;
    logic [7:0] ctr;
    logic       acc;

    n_vec    = 0;
    n_fail   = 0;
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;

    vt[0] = '{nb: 0, b0: 8'h00, b1: 8'h00, e0: 8'hBC, e1: 8'hBC, ea: 2'b00};
    vt[1] = '{nb: 2, b0: 8'hA5, b1: 8'h3C, e0: 8'hA5, e1: 8'h3C, ea: 2'b11};
    vt[2] = '{nb: 0, b0: 8'h00, b1: 8'h00, e0: 8'hBC, e1: 8'hBC, ea: 2'b00};
    vt[3] = '{nb: 1, b0: 8'hFF, b1: 8'h00, e0: 8'hFF, e1: 8'hBC, ea: 2'b01};
    vt[4] = '{nb: 1, b0: 8'h01, b1: 8'h00, e0: 8'h01, e1: 8'hBC, ea: 2'b01};
    vt[5] = '{nb: 2, b0: 8'h5A, b1: 8'hC3, e0: 8'h5A, e1: 8'hC3, ea: 2'b11};
    vt[6] = '{nb: 2, b0: 8'h00, b1: 8'h80, e0: 8'h00, e1: 8'h80, ea: 2'b11};

    // Reset state
    repeat (3) step();
    check("rst_transfer", transfer, 2'b00);
    check("rst_active", lane_active, 2'b00);
    check("rst_fs", frame_start, 1'b0);

    // Startup: seven quiet cycles, then the first load
    reset_L = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("startup_transfer_%0d", k), transfer, 2'b00);
      check($sformatf("startup_fs_%0d", k), frame_start, 1'b0);
    end
    step();
    idle_frame_check("startup_idle", 8'hBC, 8'hBC, 2'b00);

    // Table-driven frames: bytes sent in frame v appear in frame v+1
    pe0 = 8'hBC; pe1 = 8'hBC; pea = 2'b00;
    for (int v = 0; v <= 7; v++) begin
      if (v < 7) run_frame(vt[v].nb, vt[v].b0, vt[v].b1, $sformatf("vec%0d", v), c0, c1, a, fs);
      else       run_frame(0, 8'h00, 8'h00, "vec_tail", c0, c1, a, fs);
      check($sformatf("vec%0d_fs", v), fs, 1'b1);
      check($sformatf("vec%0d_lane0", v), c0, pe0);
      check($sformatf("vec%0d_lane1", v), c1, pe1);
      check($sformatf("vec%0d_active", v), a, pea);
      if (v < 7) begin
        pe0 = vt[v].e0; pe1 = vt[v].e1; pea = vt[v].ea;
      end
    end

    // Streaming: valid held high, two accepts per frame
    ctr = 8'h10;
    for (int m = 0; m <= 4; m++) begin
      fs = frame_start;
      a  = lane_active;
      for (int j = 0; j < 8; j++) begin
        c0[7-j]  = transfer[0];
        c1[7-j]  = transfer[1];
        valid_in = (m < 4);
        data_in  = ctr;
        acc      = valid_in && ready_out;
        if (m < 4) check($sformatf("stream%0d_ready_%0d", m, j), ready_out, (j < 2));
        step();
        if (acc) ctr = ctr + 8'd1;
      end
      valid_in = 1'b0;
      if (m > 0) begin
        check($sformatf("stream%0d_fs", m), fs, 1'b1);
        check($sformatf("stream%0d_lane0", m), c0, 8'h10 + 8'(2 * (m - 1)));
        check($sformatf("stream%0d_lane1", m), c1, 8'h11 + 8'(2 * (m - 1)));
        check($sformatf("stream%0d_active", m), a, 2'b11);
      end
    end
    check("stream_total", ctr, 8'h18);

    // valid_in on the load cycle is held off until the next cycle
    repeat (7) step();
    valid_in = 1'b1;
    data_in  = 8'h77;
    check("loadcyc_ready", ready_out, 1'b0);
    step();
    check("after_load_ready", ready_out, 1'b1);
    check("after_load_fs", frame_start, 1'b1);
    step();
    valid_in = 1'b0;
    repeat (7) step();
    idle_frame_check("loadcyc_frame", 8'h77, 8'hBC, 2'b01);

    // Mid-frame reset with two bytes staged
    run_frame(2, 8'hFF, 8'hFF, "prerst", c0, c1, a, fs);
    check("prerst_fs", fs, 1'b1);
    data_in = 8'h12; valid_in = 1'b1;
    check("rststage0_ready", ready_out, 1'b1);
    step();
    data_in = 8'h34;
    check("rststage1_ready", ready_out, 1'b1);
    step();
    valid_in = 1'b0;
    step();
    check("prerst_transfer", transfer, 2'b11);
    check("prerst_active", lane_active, 2'b11);
    reset_L = 1'b0;
    #2;
    check("async_rst_transfer", transfer, 2'b00);
    check("async_rst_active", lane_active, 2'b00);
    check("async_rst_fs", frame_start, 1'b0);
    step();
    reset_L = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("rerst_transfer_%0d", k), transfer, 2'b00);
    end
    step();
    idle_frame_check("postrst_idle0", 8'hBC, 8'hBC, 2'b00);
    idle_frame_check("postrst_idle1", 8'hBC, 8'hBC, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
